// File: rtl/ucomb_sweep_ctrl.sv
// ucomb_sweep_ctrl: sequences the input word of a ucomb_full array.
// A host hands over a base word and a sweep mask; every combination of the
// masked bits is applied in ascending order, held for SETTLE cycles, and the
// resulting array output is streamed back with the word that produced it.
//
// Build option: define UCOMB_SWEEP_CTRL_SIG_EN to add a 16-bit output
// signature (sig) folded over every captured result of a command.
// Assumes OUT_W <= 16 when the signature is enabled.

module ucomb_sweep_ctrl #(
  parameter int unsigned IN_W   = 27,
  parameter int unsigned OUT_W  = 6,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IN_W-1:0]  cmd_base,
  input  logic [IN_W-1:0]  cmd_mask,
  // combinational array interface
  output logic [IN_W-1:0]  comb_in,
  input  logic [OUT_W-1:0] comb_out,
  // result channel
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic [IN_W-1:0]  res_word,
  output logic             res_last,
`ifdef UCOMB_SWEEP_CTRL_SIG_EN
  output logic [15:0]      sig,
`endif
  output logic             busy
);

  // A settle time of zero would sample the array in the same cycle it is driven.
  localparam int unsigned SettleEff = (SETTLE < 1) ? 1 : SETTLE;
  localparam int unsigned CntW      = $clog2(SettleEff + 1);

  localparam logic [CntW-1:0] SettleLd = CntW'(SettleEff);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [IN_W-1:0] SweepOne = IN_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StEmit
  } state_e;

  state_e           state_q;
  logic [IN_W-1:0]  base_q;
  logic [IN_W-1:0]  mask_q;
  logic [IN_W-1:0]  sweep_q;
  logic [CntW-1:0]  cnt_q;
  logic [IN_W-1:0]  comb_in_q;
  logic [OUT_W-1:0] res_data_q;
  logic [IN_W-1:0]  res_word_q;
  logic             res_valid_q;
  logic             res_last_q;
  logic             cmd_ready_q;
  logic             busy_q;

  logic [IN_W-1:0]  cmd_base_clr;
  logic [IN_W-1:0]  sweep_nxt;
  logic             capture;

  // Next sweep value: filling the unswept positions with ones makes the
  // increment carry straight across them, so only masked bits count up.
  always_comb begin
    cmd_base_clr = cmd_base & ~cmd_mask;
    sweep_nxt    = ((sweep_q | ~mask_q) + SweepOne) & mask_q;
    capture      = (state_q == StApply) && (cnt_q == CntOne);
  end

  // Sequencer FSM; all outputs are registered so comb_in never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      base_q      <= '0;
      mask_q      <= '0;
      sweep_q     <= '0;
      cnt_q       <= '0;
      comb_in_q   <= '0;
      res_data_q  <= '0;
      res_word_q  <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            base_q      <= cmd_base_clr;
            mask_q      <= cmd_mask;
            sweep_q     <= '0;
            comb_in_q   <= cmd_base_clr;
            cnt_q       <= SettleLd;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StApply;
          end
        end

        StApply: begin
          cnt_q <= cnt_q - CntOne;
          if (capture) begin
            res_data_q  <= comb_out;
            res_word_q  <= comb_in_q;
            res_last_q  <= (sweep_q == mask_q);
            res_valid_q <= 1'b1;
            state_q     <= StEmit;
          end
        end

        StEmit: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (res_last_q) begin
              // comb_in deliberately keeps the final word applied.
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StIdle;
            end else begin
              sweep_q   <= sweep_nxt;
              comb_in_q <= base_q | sweep_nxt;
              cnt_q     <= SettleLd;
              state_q   <= StApply;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef UCOMB_SWEEP_CTRL_SIG_EN
  logic [15:0] sig_q;
  logic [15:0] sig_mix;

  // Zero-extend the captured array output into the signature width.
  always_comb begin
    sig_mix              = '0;
    sig_mix[OUT_W-1:0]   = comb_out;
  end

  // LFSR-style signature: cleared per command, folded on each capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if ((state_q == StIdle) && cmd_valid) begin
      sig_q <= '0;
    end else if (capture) begin
      sig_q <= {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ sig_mix;
    end
  end

  assign sig = sig_q;
`endif

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign comb_in   = comb_in_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_word  = res_word_q;
  assign res_last  = res_last_q;

endmodule

// File: tb/tb_ucomb_sweep_ctrl.sv
// Self-checking bench for ucomb_sweep_ctrl with a scoreboard of expected
// results. Define UCOMB_SWEEP_CTRL_SIG_EN for both files to cover sig.

module tb_ucomb_sweep_ctrl;

  localparam int IN_W   = 27;
  localparam int OUT_W  = 6;
  localparam int SETTLE = 2;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [IN_W-1:0]  cmd_base;
  logic [IN_W-1:0]  cmd_mask;
  logic [IN_W-1:0]  comb_in;
  logic [OUT_W-1:0] comb_out;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic [IN_W-1:0]  res_word;
  logic             res_last;
  logic             busy;
`ifdef UCOMB_SWEEP_CTRL_SIG_EN
  logic [15:0]      sig;
`endif

  typedef struct packed {
    logic [IN_W-1:0]  word;
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;
  int   hs_count;

  // Stand-in for the ucomb_full array: a fixed mix of gates over the word.
  function automatic logic [OUT_W-1:0] ucomb_model(input logic [IN_W-1:0] w);
    logic [OUT_W-1:0] o;
    o[0] = ^w;
    o[1] = w[0] & w[1];
    o[2] = w[2] | w[26];
    o[3] = ^w[7:0] ~^ w[4];
    o[4] = w[3] ^ w[26] ^ w[1];
    o[5] = (&w[26:20]) | (w[1] & ~w[3]);
    return o;
  endfunction

  assign comb_out = ucomb_model(comb_in);

  ucomb_sweep_ctrl #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SETTLE(SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base (cmd_base),
    .cmd_mask (cmd_mask),
    .comb_in  (comb_in),
    .comb_out (comb_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_word (res_word),
    .res_last (res_last),
`ifdef UCOMB_SWEEP_CTRL_SIG_EN
    .sig      (sig),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_word", 32'(res_word), 32'(e.word));
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_last", 32'(res_last), 32'(e.last));
      end
      hs_count++;
    end
  end

  // Offer a command for one edge and enqueue its results in ascending order.
  task automatic send_cmd(input logic [IN_W-1:0] base, input logic [IN_W-1:0] mask);
    int npop;
    check("cmd_ready_pre", 32'(cmd_ready), 32'd1);
    npop = $countones(mask);
    for (int k = 0; k < (1 << npop); k++) begin
      exp_t e;
      logic [IN_W-1:0] w;
      int j;
      w = base & ~mask;
      j = 0;
      for (int b = 0; b < IN_W; b++) begin
        if (mask[b]) begin
          if (((k >> j) & 1) != 0) w[b] = 1'b1;
          j++;
        end
      end
      e.word = w;
      e.data = ucomb_model(w);
      e.last = (k == (1 << npop) - 1);
      exp_q.push_back(e);
    end
    cmd_base  = base;
    cmd_mask  = mask;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Count edges until the block is idle again; an expired budget is a failure.
  task automatic wait_idle(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (cmd_ready) break;
    end
    if (!cmd_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (hs_count >= target) break;
      @(posedge clk);
      #1;
    end
    if (hs_count < target) check("hs_timeout", 32'(hs_count), 32'(target));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_comb_in"}, 32'(comb_in), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_word"}, 32'(res_word), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_res_last"}, 32'(res_last), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Single-vector command with cycle-exact latency checks.
  task automatic run_single(input string tag);
    send_cmd(27'h0000006, '0);
    check({tag, "_comb_in"}, 32'(comb_in), 32'h6);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_valid_early"}, 32'(res_valid), 32'd0);
    for (int i = 1; i < SETTLE; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_valid_early"}, 32'(res_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    check({tag, "_valid_on_time"}, 32'(res_valid), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_back_idle"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [IN_W-1:0] w0;
    logic [IN_W-1:0] c0;
    n_vec     = 0;
    n_err     = 0;
    hs_count  = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_base  = '0;
    cmd_mask  = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: mask 0 gives exactly one result
    run_single("t1");

    // 2: two-bit sweep, full throughput
    send_cmd(27'h7FFFFFF, 27'h0000003);
    wait_idle(200, n);
    check("t2_cycles", 32'(n), 32'(4 * (SETTLE + 1)));
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: non-contiguous mask
    send_cmd(27'h0000000, 27'h4000010);
    wait_idle(200, n);
    check("t3_cycles", 32'(n), 32'(4 * (SETTLE + 1)));
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: backpressure at the second result, plus a command offered while busy
    hs_count = 0;
    send_cmd(27'h7FFFFFF, 27'h0000003);
    wait_hs(1, 50);
    res_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) break;
      @(posedge clk);
      #1;
    end
    check("t4_valid", 32'(res_valid), 32'd1);
    check("t4_word", 32'(res_word), 32'h7FFFFFD);
    w0 = res_word;
    c0 = comb_in;
    cmd_base  = 27'h0000055;
    cmd_mask  = 27'h0000000;
    cmd_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("t4_hold_valid", 32'(res_valid), 32'd1);
      check("t4_hold_word", 32'(res_word), 32'(w0));
      check("t4_hold_comb_in", 32'(comb_in), 32'(c0));
      check("t4_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle(200, n);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_hs_count", 32'(hs_count), 32'd4);

    // random bases and masks with random consumer stalls
    for (int c = 0; c < 4; c++) begin
      logic [IN_W-1:0] b;
      logic [IN_W-1:0] m;
      b = IN_W'($urandom());
      m = '0;
      for (int i = 0; i < 3; i++) m[$urandom_range(0, IN_W - 1)] = 1'b1;
      send_cmd(b, m);
      for (int i = 0; i < 400; i++) begin
        res_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (cmd_ready) break;
      end
      res_ready = 1'b1;
      check("rnd_idle", 32'(cmd_ready), 32'd1);
      check("rnd_drained", 32'(exp_q.size()), 32'd0);
    end

    // 5: reset while applying the third result
    hs_count = 0;
    send_cmd(27'h7FFFFFF, 27'h0000003);
    wait_hs(2, 50);
    check("t5_in_apply", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_reset_vals("t5_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_single("t5_after");

`ifdef UCOMB_SWEEP_CTRL_SIG_EN
    // 6: signature over a four-bit sweep, cleared on the next accept
    begin
      logic [15:0] s;
      logic [15:0] mix;
      s = '0;
      for (int k = 0; k < 16; k++) begin
        mix = '0;
        mix[OUT_W-1:0] = ucomb_model(IN_W'(k));
        s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ mix;
      end
      send_cmd(27'h0000000, 27'h000000F);
      wait_idle(400, n);
      check("t6_sig", 32'(sig), 32'(s));
      check("t6_drained", 32'(exp_q.size()), 32'd0);
      send_cmd(27'h0000001, 27'h0000000);
      check("t6_sig_clear", 32'(sig), 32'd0);
      wait_idle(200, n);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ucomb_sweep_ctrl.md
Name: ucomb_sweep_ctrl

Overview:
Sequencer that drives the 27-bit input word of a ucomb_full instance and captures its 6-bit output. A host issues one command through a valid/ready handshake. The command gives a base word and a sweep mask. The block applies every combination of the masked bits in ascending order, waits a settle time for each, and streams the captured outputs back through a second valid/ready handshake. It sits between the host/test logic and the combinational universal-gate array, and is the only driver of that array's inputs.

Parameters:
IN_W, 27, width of the combinational input word (matches ucomb_full)
OUT_W, 6, width of the combinational output word
SETTLE, 2, cycles comb_in is held before comb_out is sampled; values below 1 are treated as 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_base  in  IN_W  fixed bits of the input word
cmd_mask  in  IN_W  bits to sweep (1 = swept)
comb_in  out  IN_W  registered drive to ucomb_full in
comb_out  in  OUT_W  ucomb_full out
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  OUT_W  captured comb_out
res_word  out  IN_W  comb_in value that produced res_data
res_last  out  1  final result of the current command
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; all of comb_in, res_data, res_word, res_valid, res_last, sweep and counters are 0. cmd_ready=1, busy=0.
- States: IDLE, APPLY, EMIT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch base_r = cmd_base & ~cmd_mask and mask_r = cmd_mask; set sweep=0 and comb_in = base_r; load settle counter = SETTLE; go to APPLY.
- APPLY:
  - Counter decrements each cycle.
  - On the edge where it reaches 0: capture res_data <= comb_out, res_word <= comb_in, res_last <= (sweep == mask_r); go to EMIT.
  - Accept edge to res_valid high takes exactly SETTLE cycles.
- EMIT:
  - res_valid=1. res_data, res_word and res_last are held stable until the handshake.
  - On res_valid&res_ready with res_last=1: go to IDLE. comb_in keeps its last value.
  - On res_valid&res_ready with res_last=0: sweep <= ((sweep | ~mask_r) + 1) & mask_r; comb_in <= base_r | that next value; reload the counter; go to APPLY. res_valid drops for SETTLE cycles.
- Sweep arithmetic is IN_W bits wide; the carry out of the MSB is discarded.
- Results per command = 2^popcount(mask), in ascending numeric order of the swept bits.
- mask=0: exactly one result, with res_last=1.
- Throughput with res_ready tied high: one result per SETTLE+1 cycles.
- cmd_valid outside IDLE is ignored. No queuing.
- Backpressure: EMIT holds indefinitely. comb_in does not change while res_valid=1.
- Reset asserted mid-command: everything returns to reset values immediately. Pending results are discarded and no res_last is emitted.
- comb_in changes only on a command accept or an EMIT handshake, so the combinational array sees glitch-free registered inputs.

Optional Feature:
- Macro: UCOMB_SWEEP_CTRL_SIG_EN.
- When defined:
  - Adds output port sig, 16 bits.
  - sig is cleared on command accept.
  - On every APPLY capture edge: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {10'b0, comb_out}.
  - sig holds its value after the command ends.
  - Reset value is 0.
  - Purpose: compact signature for full-array sweeps.
- When not defined: port sig and its logic are absent; all other behaviour is identical.

Test Plan:
1. Single vector. SETTLE=2, cmd_base=27'h0000006, cmd_mask=0, res_ready=1.
   -> comb_in=27'h0000006 one cycle after accept.
   -> res_valid two cycles after accept, with res_word=27'h0000006, res_data equal to the model output, res_last=1.
   -> Back in IDLE the next cycle (cmd_ready=1).
2. Two-bit sweep. cmd_base=27'h7FFFFFF, cmd_mask=27'h0000003.
   -> Four results with res_word = 27'h7FFFFFC, 7FFFFFD, 7FFFFFE, 7FFFFFF.
   -> res_last only on the fourth result.
3. Non-contiguous mask. cmd_mask=27'h4000010, base=0.
   -> res_word sequence 0, 27'h10, 27'h4000000, 27'h4000010.
4. Backpressure. During scenario 2, hold res_ready=0 for 5 cycles at the second result.
   -> res_valid, res_word and comb_in stay constant.
   -> No result is lost or duplicated.
   -> A cmd_valid asserted while busy is ignored.
5. Reset mid-sweep. Assert rst in APPLY of the third result of scenario 2.
   -> Outputs go to 0 and busy to 0 asynchronously.
   -> A new command afterwards behaves as in scenario 1.
6. With UCOMB_SWEEP_CTRL_SIG_EN defined, sweep cmd_mask=27'h000000F, base=0, against the reference model.
   -> sig equals the model-computed signature after res_last.
   -> sig is cleared on the next accept.
